// File: rtl/zclk_phase_seq.sv
// 28MHz phase strobe generator for the Z80 clock path, plus turbo-change sequencing
// that applies a new CPU speed on a refresh cycle, or after a watchdog timeout.
//
// state   | meaning
// S_IDLE  | no change armed; watchdog runs while a change is pending
// S_ARMED | change armed by a refresh or by the watchdog, applied on the next c3 edge
module zclk_phase_seq #(
    parameter logic [1:0] TURBO_RST   = 2'b00,
    parameter int         SYNC_STAGES = 2,
    parameter int         WDOG_CYC    = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rfsh_n,
    input  logic [1:0] turbo_req,
    output logic       c0,
    output logic       c1,
    output logic       c2,
    output logic       c3,
    output logic       c14mhz,
    output logic [1:0] turbo,
    output logic       turbo_pending,
    output logic       turbo_chg
);

    localparam int                WDOG_W    = $clog2(WDOG_CYC);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYC - 1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ARMED = 1'b1
    } seq_state_t;

    seq_state_t              state, state_nxt;
    logic [1:0]              phase;
    logic [3:0]              strb;
    logic [SYNC_STAGES-1:0]  rfsh_sync;
    logic                    rfsh_prev;
    logic                    rfsh_fall;
    logic [WDOG_W-1:0]       wdog, wdog_nxt;
    logic [1:0]              turbo_nxt;
    logic                    chg_nxt;
    logic                    pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase  <= 2'd0;
            strb   <= 4'b0000;
            c14mhz <= 1'b0;
        end else begin
            phase  <= phase + 2'd1;
            strb   <= 4'b0001 << phase;
            c14mhz <= phase[0];
        end
    end

    assign c0 = strb[0];
    assign c1 = strb[1];
    assign c2 = strb[2];
    assign c3 = strb[3];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rfsh_sync <= '1;
            rfsh_prev <= 1'b1;
        end else begin
            rfsh_sync <= {rfsh_sync[SYNC_STAGES-2:0], rfsh_n};
            rfsh_prev <= rfsh_sync[SYNC_STAGES-1];
        end
    end

    assign rfsh_fall = rfsh_prev & ~rfsh_sync[SYNC_STAGES-1];
    assign pend      = (turbo_req != turbo);

    // Apply is gated on phase==3 so the new turbo lands in the same cycle as c3.
    always_comb begin
        state_nxt = state;
        turbo_nxt = turbo;
        chg_nxt   = 1'b0;
        wdog_nxt  = '0;
        case (state)
            S_IDLE: begin
                if (pend) begin
                    if (rfsh_fall || (wdog == WDOG_LAST)) begin
                        state_nxt = S_ARMED;
                    end else begin
                        wdog_nxt = wdog + WDOG_W'(1);
                    end
                end
            end
            S_ARMED: begin
                if (!pend) begin
                    state_nxt = S_IDLE;
                end else if (phase == 2'd3) begin
                    state_nxt = S_IDLE;
                    turbo_nxt = turbo_req;
                    chg_nxt   = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            wdog          <= '0;
            turbo         <= TURBO_RST;
            turbo_chg     <= 1'b0;
            turbo_pending <= 1'b0;
        end else begin
            state         <= state_nxt;
            wdog          <= wdog_nxt;
            turbo         <= turbo_nxt;
            turbo_chg     <= chg_nxt;
            turbo_pending <= pend;
        end
    end

endmodule

// File: tb/tb_zclk_phase_seq.sv
// Bench for zclk_phase_seq: a cycle model driven by edge count, rfsh history and
// pending-run length, checked every cycle, plus directed literal checks per scenario.
module tb_zclk_phase_seq;

    localparam int         S    = 2;
    localparam int         WDOG = 16;
    localparam logic [1:0] TRST = 2'b00;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rfsh_n = 1'b1;
    logic [1:0] turbo_req = 2'b00;
    logic       c0, c1, c2, c3, c14mhz;
    logic [1:0] turbo;
    logic       turbo_pending, turbo_chg;

    int n_checks = 0;
    int n_fail   = 0;

    zclk_phase_seq #(
        .TURBO_RST  (TRST),
        .SYNC_STAGES(S),
        .WDOG_CYC   (WDOG)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .rfsh_n       (rfsh_n),
        .turbo_req    (turbo_req),
        .c0           (c0),
        .c1           (c1),
        .c2           (c2),
        .c3           (c3),
        .c14mhz       (c14mhz),
        .turbo        (turbo),
        .turbo_pending(turbo_pending),
        .turbo_chg    (turbo_chg)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: phase from edges since release, refresh falls from sampled history,
    // watchdog from length of the current un-armed pending run.
    int         m_edges;
    logic       m_hist [0:S];
    logic [1:0] m_turbo;
    logic       m_armed;
    int         m_run;
    logic [3:0] e_strb;
    logic       e_c14, e_pend, e_chg;
    logic [1:0] e_turbo;

    task model_reset();
        m_edges = -1;
        for (int j = 0; j <= S; j++) m_hist[j] = 1'b1;
        m_turbo = TRST;
        m_armed = 1'b0;
        m_run   = 0;
        e_strb  = 4'b0000;
        e_c14   = 1'b0;
        e_pend  = 1'b0;
        e_chg   = 1'b0;
        e_turbo = TRST;
    endtask

    task model_step();
        int  ph;
        bit  fall, pend, apply;
        fall = m_hist[S] && !m_hist[S-1];
        for (int j = S; j > 0; j--) m_hist[j] = m_hist[j-1];
        m_hist[0] = rfsh_n;
        m_edges++;
        ph    = m_edges % 4;
        pend  = (turbo_req != m_turbo);
        apply = (ph == 3) && m_armed && pend;
        e_pend = pend;
        e_chg  = apply;
        if (apply) begin
            m_turbo = turbo_req;
            m_armed = 1'b0;
            m_run   = 0;
        end else if (!pend) begin
            m_armed = 1'b0;
            m_run   = 0;
        end else if (m_armed) begin
            m_run = 0;
        end else begin
            m_run++;
            if (fall || m_run == WDOG) begin
                m_armed = 1'b1;
                m_run   = 0;
            end
        end
        e_strb  = 4'(1 << ph);
        e_c14   = (ph % 2) == 1;
        e_turbo = m_turbo;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    always @(posedge clk) begin
        #2;
        check("cyc_strobes", {c3, c2, c1, c0}, e_strb);
        check("cyc_c14mhz", c14mhz, e_c14);
        check("cyc_turbo", turbo, e_turbo);
        check("cyc_pending", turbo_pending, e_pend);
        check("cyc_chg", turbo_chg, e_chg);
    end

    task automatic align();
        int k = 0;
        @(negedge clk);
        while (c3 !== 1'b1 && k < 8) begin
            @(negedge clk);
            k++;
        end
        check("align_c3", c3, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout reached at %0t", $time);
        $fatal(1);
    end

    initial begin
        int cnt [4];
        int c14_cnt, multi, chg_cnt;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // 1: free-running phases
        for (int i = 0; i < 4; i++) cnt[i] = 0;
        c14_cnt = 0;
        multi   = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i == 0) check("t1_first_c0", {c3, c2, c1, c0}, 4'b0001);
            cnt[0] += c0; cnt[1] += c1; cnt[2] += c2; cnt[3] += c3;
            c14_cnt += c14mhz;
            if ((c0 + c1 + c2 + c3) != 1) multi++;
        end
        check("t1_c0_cnt", 4'(cnt[0]), 4'd4);
        check("t1_c1_cnt", 4'(cnt[1]), 4'd4);
        check("t1_c2_cnt", 4'(cnt[2]), 4'd4);
        check("t1_c3_cnt", 4'(cnt[3]), 4'd4);
        check("t1_c14_cnt", 4'(c14_cnt), 4'd8);
        check("t1_onehot", 4'(multi), 4'd0);

        // 2: refresh-triggered change 00 -> 10
        align();
        turbo_req = 2'b10;
        rfsh_n    = 1'b0;
        @(negedge clk);
        check("t2_pend_set", turbo_pending, 1'b1);
        repeat (3) @(negedge clk);
        check("t2_turbo", turbo, 2'b10);
        check("t2_chg", turbo_chg, 1'b1);
        check("t2_c3", c3, 1'b1);
        @(negedge clk);
        check("t2_chg_low", turbo_chg, 1'b0);
        check("t2_pend_clear", turbo_pending, 1'b0);
        repeat (3) @(negedge clk);
        rfsh_n = 1'b1;
        repeat (8) @(negedge clk);

        // 3: watchdog-forced change 10 -> 01
        align();
        turbo_req = 2'b01;
        repeat (15) @(negedge clk);
        check("t3_early", turbo, 2'b10);
        repeat (4) @(negedge clk);
        check("t3_before", turbo, 2'b10);
        @(negedge clk);
        check("t3_turbo", turbo, 2'b01);
        check("t3_chg", turbo_chg, 1'b1);
        repeat (4) @(negedge clk);

        // 4: request withdrawn while armed
        align();
        turbo_req = 2'b10;
        rfsh_n    = 1'b0;
        repeat (3) @(negedge clk);
        turbo_req = 2'b01;
        @(negedge clk);
        check("t4_turbo", turbo, 2'b01);
        check("t4_chg", turbo_chg, 1'b0);
        check("t4_pend", turbo_pending, 1'b0);
        chg_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chg_cnt += turbo_chg;
        end
        check("t4_no_chg", 4'(chg_cnt), 4'd0);
        rfsh_n = 1'b1;
        repeat (6) @(negedge clk);
        align();
        turbo_req = 2'b10;
        repeat (4) @(negedge clk);
        check("t4_armed_clear", turbo, 2'b01);
        turbo_req = 2'b01;
        repeat (4) @(negedge clk);

        // 5: request retargeted while armed
        align();
        turbo_req = 2'b10;
        rfsh_n    = 1'b0;
        repeat (3) @(negedge clk);
        turbo_req = 2'b11;
        @(negedge clk);
        check("t5_turbo", turbo, 2'b11);
        check("t5_chg", turbo_chg, 1'b1);
        chg_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 4) rfsh_n = 1'b1;
            chg_cnt += turbo_chg;
        end
        check("t5_single_chg", 4'(chg_cnt), 4'd0);

        // 6: reset while armed, mid-phase
        align();
        turbo_req = 2'b00;
        rfsh_n    = 1'b0;
        repeat (3) @(negedge clk);
        check("t6_mid_c2", {c3, c2, c1, c0}, 4'b0100);
        rst_n = 1'b0;
        #1;
        check("t6_rst_strobes", {c3, c2, c1, c0}, 4'b0000);
        check("t6_rst_c14", c14mhz, 1'b0);
        check("t6_rst_turbo", turbo, TRST);
        check("t6_rst_pend", turbo_pending, 1'b0);
        check("t6_rst_chg", turbo_chg, 1'b0);
        turbo_req = 2'b01;
        rfsh_n    = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("t6_restart_c0", {c3, c2, c1, c0}, 4'b0001);
        check("t6_turbo_rst", turbo, TRST);
        repeat (18) @(negedge clk);
        check("t6_wd_before", turbo, 2'b00);
        @(negedge clk);
        check("t6_wd_apply", turbo, 2'b01);
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
